// File: rtl/axi4_stream_master_bram.sv
// axi4_stream_master_bram: streams DATA_NUM words from a 1-cycle BRAM as
// one AXI4-Stream frame per in_start pulse.
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   in_start               request one frame read-out (ignored while busy)
//   out_busy, out_done     frame in progress / 1-cycle completion pulse
//   out_m_t*, in_m_tready  AXIS master (tvalid/tready/tdata/tkeep/tlast)
//   out_A, out_EN, out_WE  BRAM read port address/enable/write-enable
//   in_Do                  BRAM read data, valid the cycle after out_EN
module axi4_stream_master_bram #(
  parameter  int DATA_NUM   = 11,
  parameter  int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    in_start,
  output logic                    out_busy,
  output logic                    out_done,
  output logic                    out_m_tvalid,
  input  logic                    in_m_tready,
  output logic [DATA_WIDTH-1:0]   out_m_tdata,
  output logic [DATA_WIDTH/8-1:0] out_m_tkeep,
  output logic                    out_m_tlast,
  output logic [ADDR_WIDTH-1:0]   out_A,
  output logic                    out_EN,
  output logic [DATA_WIDTH/8-1:0] out_WE,
  input  logic [DATA_WIDTH-1:0]   in_Do
);

  // Counter must also hold DATA_NUM to mean "all reads issued".
  localparam int CNT_W = $clog2(DATA_NUM + 1);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] rd_cnt;
  logic             rd_more;
  logic             rd_last;
  logic             issue;
  logic             room;

  logic             inflight;
  logic             inflight_last;

  // Two-entry output buffer: hd_* is the head presented on the bus.
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] hd_data;
  logic                  hd_last;
  logic [DATA_WIDTH-1:0] tl_data;
  logic                  tl_last;

  logic pop;
  logic push;
  logic fire_last;

  assign pop       = out_m_tvalid & in_m_tready;
  assign push      = inflight;
  assign fire_last = pop & hd_last;

  assign rd_more = (rd_cnt < CNT_W'(DATA_NUM));
  assign rd_last = (rd_cnt == CNT_W'(DATA_NUM - 1));

  // A new read is allowed only if the word it returns is guaranteed a
  // free slot: entries held + word in flight - word leaving now < 2.
  assign room = ({1'b0, occ} + {2'b00, inflight})
              < (pop ? 3'd3 : 3'd2);

  assign out_m_tvalid = (occ != 2'd0);
  assign out_m_tdata  = hd_data;
  assign out_m_tlast  = hd_last;
  assign out_m_tkeep  = '1;
  assign out_WE       = '0;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    out_busy  = 1'b0;
    out_EN    = 1'b0;
    out_A     = '0;
    unique case (state)
      IDLE: begin
        if (in_start) begin
          state_nxt = READ;
        end
      end
      READ: begin
        out_busy = 1'b1;
        issue    = rd_more & room;
        out_EN   = issue;
        if (issue) begin
          out_A = rd_cnt[ADDR_WIDTH-1:0];
        end
        if (fire_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      out_done      <= 1'b0;
    end else begin
      if (state == IDLE && in_start) begin
        rd_cnt <= '0;
      end else if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      inflight      <= issue;
      inflight_last <= issue & rd_last;
      out_done      <= fire_last;
    end
  end

  // Clearing inflight on reset drops any word still returning from
  // a read issued before reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      occ     <= 2'd0;
      hd_data <= '0;
      hd_last <= 1'b0;
      tl_data <= '0;
      tl_last <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          occ <= occ + 2'd1;
          if (occ == 2'd0) begin
            hd_data <= in_Do;
            hd_last <= inflight_last;
          end else begin
            tl_data <= in_Do;
            tl_last <= inflight_last;
          end
        end
        2'b01: begin
          occ     <= occ - 2'd1;
          hd_data <= tl_data;
          hd_last <= tl_last;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            hd_data <= in_Do;
            hd_last <= inflight_last;
          end else begin
            hd_data <= tl_data;
            hd_last <= tl_last;
            tl_data <= in_Do;
            tl_last <= inflight_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_stream_master_bram.sv
// tb_axi4_stream_master_bram: directed and randomized frames checked
// against a frame-level scoreboard and a behavioural BRAM.
module tb_axi4_stream_master_bram;

  localparam int N  = 11;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          in_start;
  logic          out_busy;
  logic          out_done;
  logic          out_m_tvalid;
  logic          in_m_tready;
  logic [DW-1:0] out_m_tdata;
  logic [3:0]    out_m_tkeep;
  logic          out_m_tlast;
  logic [AW-1:0] out_A;
  logic          out_EN;
  logic [3:0]    out_WE;
  logic [DW-1:0] in_Do = '0;

  always #5 aclk = ~aclk;

  axi4_stream_master_bram #(
    .DATA_NUM  (N),
    .DATA_WIDTH(DW)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .in_start    (in_start),
    .out_busy    (out_busy),
    .out_done    (out_done),
    .out_m_tvalid(out_m_tvalid),
    .in_m_tready (in_m_tready),
    .out_m_tdata (out_m_tdata),
    .out_m_tkeep (out_m_tkeep),
    .out_m_tlast (out_m_tlast),
    .out_A       (out_A),
    .out_EN      (out_EN),
    .out_WE      (out_WE),
    .in_Do       (in_Do)
  );

  logic [DW-1:0] mem [N];

  always @(posedge aclk) begin
    if (out_EN && int'(out_A) < N) in_Do <= mem[out_A];
  end

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [32:0] exp_q [$];
  bit          model_busy  = 0;
  bit          done_exp    = 0;
  bit          prev_stall  = 0;
  bit          after_reset = 0;
  logic [31:0] prev_data   = '0;
  logic        prev_last   = 1'b0;
  int exp_addr = 0;
  int issued = 0;
  int accepted = 0;
  int frame_beats = 0;
  int issued_frame = 0;
  int t_start = 0;
  int t_first = 0;
  int t_last = 0;
  int t_done = 0;
  int n_done = 0;
  int nd = 0;
  int guard = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input logic st, input logic rn);
    logic        fire;
    logic        last_beat;
    logic        start_ok;
    logic [32:0] e;
    fire      = out_m_tvalid && in_m_tready;
    last_beat = 1'b0;
    if (after_reset) begin
      chk("rst_tvalid", out_m_tvalid, 0);
      chk("rst_tlast", out_m_tlast, 0);
      chk("rst_tdata", out_m_tdata, 0);
      chk("rst_busy", out_busy, 0);
      chk("rst_en", out_EN, 0);
      chk("rst_addr", out_A, 0);
      chk("rst_done", out_done, 0);
      after_reset = 0;
    end
    chk("busy", out_busy, model_busy);
    chk("done", out_done, done_exp);
    chk("we", out_WE, 0);
    if (prev_stall) begin
      chk("hold_valid", out_m_tvalid, 1);
      chk("hold_data", out_m_tdata, prev_data);
      chk("hold_last", out_m_tlast, prev_last);
    end
    if (out_m_tvalid) chk("keep", out_m_tkeep, 4'hf);
    if (out_EN) begin
      chk("addr", out_A, exp_addr);
      chk("addr_range", exp_addr < N, 1);
      exp_addr++;
      issued++;
      issued_frame++;
    end else begin
      chk("addr_idle", out_A, 0);
    end
    if (fire) begin
      accepted++;
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tdata", out_m_tdata, e[31:0]);
        chk("tlast", out_m_tlast, e[32]);
        if (frame_beats == 0) t_first = cyc;
        if (e[32]) begin
          t_last    = cyc;
          last_beat = 1'b1;
        end
        frame_beats++;
      end
    end
    chk("outstanding", (issued - accepted) <= 2, 1);
    if (out_done) begin
      n_done++;
      t_done = cyc;
    end
    prev_stall = out_m_tvalid && !in_m_tready;
    prev_data  = out_m_tdata;
    prev_last  = out_m_tlast;
    start_ok   = st && !model_busy && rn;
    done_exp   = last_beat;
    if (last_beat) model_busy = 0;
    if (!rn) begin
      model_busy  = 0;
      done_exp    = 0;
      prev_stall  = 0;
      exp_q.delete();
      issued      = 0;
      accepted    = 0;
      after_reset = 1;
    end else if (start_ok) begin
      model_busy   = 1;
      exp_addr     = 0;
      frame_beats  = 0;
      issued_frame = 0;
      t_start      = cyc;
      for (int k = 0; k < N; k++) begin
        exp_q.push_back({(k == N - 1), mem[k]});
      end
    end
  endtask

  task automatic step(input logic st, input logic rdy,
                      input logic rn);
    in_start    = st;
    in_m_tready = rdy;
    aresetn     = rn;
    #2;
    check_cycle(st, rn);
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  function automatic logic rdy_of(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (i % 2) == 0;
    return ($urandom % 4) != 0;
  endfunction

  task automatic run_idle(input int mode);
    int i;
    logic st;
    i = 0;
    while ((model_busy || exp_q.size() != 0 || done_exp) && i < 400) begin
      st = (mode == 2) ? (($urandom % 8) == 0) : 1'b0;
      step(st, rdy_of(mode, i), 1'b1);
      i++;
    end
    chk("frame_timeout", i < 400, 1);
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) mem[k] = 32'h100 + k;
  endtask

  initial begin
    fill_ramp();
    aresetn     = 1'b0;
    in_start    = 1'b0;
    in_m_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    after_reset = 1;
    step(0, 1, 1);
    step(0, 1, 1);

    // basic frame timing, tready steady
    nd = n_done;
    step(1, 1, 1);
    run_idle(0);
    chk("lat_first", t_first - t_start, 3);
    chk("lat_last", t_last - t_start, 13);
    chk("lat_done", t_done - t_start, 14);
    chk("beats_s1", frame_beats, N);
    chk("dones_s1", n_done - nd, 1);
    step(0, 1, 1);

    // alternating tready
    nd = n_done;
    step(1, 1, 1);
    run_idle(1);
    chk("beats_alt", frame_beats, N);
    chk("dones_alt", n_done - nd, 1);

    // long stall right after first tvalid
    step(1, 0, 1);
    guard = 0;
    while (!out_m_tvalid && guard < 10) begin
      step(0, 0, 1);
      guard++;
    end
    chk("stall_wait", guard < 10, 1);
    repeat (20) step(0, 0, 1);
    chk("stall_valid", out_m_tvalid, 1);
    chk("stall_data", out_m_tdata, 32'h100);
    chk("stall_reads", issued_frame, 2);
    run_idle(0);
    chk("beats_stall", frame_beats, N);

    // start re-pulsed mid-frame
    nd = n_done;
    step(1, 1, 1);
    repeat (4) step(0, 1, 1);
    step(1, 1, 1);
    run_idle(0);
    chk("beats_restart", frame_beats, N);
    chk("dones_restart", n_done - nd, 1);

    // reset mid-frame, then replay
    step(1, 1, 1);
    repeat (5) step(0, 1, 1);
    step(0, 1, 0);
    repeat (3) step(0, 1, 1);
    step(1, 1, 1);
    run_idle(0);
    chk("replay_first", t_first - t_start, 3);
    chk("beats_replay", frame_beats, N);

    // back-to-back frames, start in the done cycle
    step(1, 1, 1);
    guard = 0;
    while (!done_exp && guard < 50) begin
      step(0, 1, 1);
      guard++;
    end
    chk("b2b_wait", guard < 50, 1);
    step(1, 1, 1);
    chk("b2b_started", model_busy, 1);
    run_idle(0);
    chk("b2b_first", t_first - t_start, 3);
    chk("beats_b2b", frame_beats, N);

    // randomized contents, tready and spurious starts
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < N; k++) mem[k] = $urandom;
      step(1, rdy_of(2, 0), 1);
      run_idle(2);
      repeat ($urandom_range(0, 2)) step(0, 1, 1);
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4_stream_master_bram.md
AXI4_STREAM_MASTER_BRAM -- requirements
Module: axi4_stream_master_bram

Interface
REQ-001 SHALL have parameter DATA_NUM, default 11: words per frame, at least 1.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width, a multiple of 8.
REQ-003 SHALL derive localparam ADDR_WIDTH = max(1, ceil(log2(DATA_NUM))).
REQ-004 SHALL use one clock; reset is synchronous and active-low: aclk in 1 (rising edge), aresetn in 1 (sync, active-low).
REQ-005 SHALL have in_start  in  1  pulse requesting one frame read-out.
REQ-006 SHALL have out_busy  out  1  frame in progress.
REQ-007 SHALL have out_done  out  1  one-cycle pulse at frame completion.
REQ-008 SHALL have out_m_tvalid  out  1  and  in_m_tready  in  1: AXIS master handshake.
REQ-009 SHALL have out_m_tdata  out  DATA_WIDTH,  out_m_tkeep  out  DATA_WIDTH/8,  out_m_tlast  out  1.
REQ-010 SHALL have out_A  out  ADDR_WIDTH,  out_EN  out  1,  out_WE  out  DATA_WIDTH/8,  in_Do  in  DATA_WIDTH: BRAM read port.

Function
REQ-011 SHALL use FSM states IDLE and READ; IDLE->READ on in_start in IDLE; READ->IDLE on the handshake with tlast=1; in_start in READ is ignored.
REQ-012 SHALL treat the BRAM as 1-cycle read latency: in_Do is valid the cycle after out_EN=1 with out_A.
REQ-013 SHALL keep a read counter (0..DATA_NUM-1, reset to 0 on IDLE->READ) and issue a read (out_EN=1, out_A=counter, counter+1) in READ when counter<DATA_NUM and occupancy+inflight-pop < 2, where occupancy = output buffer entries (0..2), inflight = read issued last cycle, pop = tvalid&&tready this cycle.
REQ-014 SHALL drive out_A=0 whenever out_EN=0, and out_WE=0 at all times.
REQ-015 SHALL capture in_Do into a 2-entry FIFO output buffer; tvalid=(occupancy>0); tdata/tlast come from the head entry registers.
REQ-016 SHALL, once tvalid=1, hold tvalid, tdata, and tlast stable until a handshake occurs.
REQ-017 SHALL set tlast=1 only on the beat carrying address DATA_NUM-1, and tkeep to all ones.
REQ-018 SHALL meet the following latency: in_start at cycle 0 -> out_EN/out_A=0 at cycle 1 -> tvalid with word 0 at cycle 3; with tready=1 steady, one beat per cycle, tlast at cycle DATA_NUM+2.
REQ-019 SHALL assert out_busy from the IDLE->READ transition through the tlast handshake cycle, and pulse out_done for exactly the cycle after the tlast handshake (FSM in IDLE).
REQ-020 SHALL accept in_start in the out_done cycle, starting a new frame from address 0.
REQ-021 SHALL never overflow the buffer or drop a returned word under any tready pattern.

Reset
REQ-022 SHALL, on the first edge with aresetn=0 (including mid-frame), go to IDLE, clear the counter, occupancy, and inflight, and drive out_m_tvalid, out_m_tlast, out_busy, out_done, out_EN, out_A, and out_m_tdata to 0.
REQ-023 SHALL discard any in_Do returning from a read issued before reset.

Verification
REQ-024 SHALL pass this scenario: DATA_NUM=11, mem[k]=0x100+k, tready=1, in_start at cycle 0 -> beats 0x100..0x10A at cycles 3..13, tlast only on 0x10A, out_done at cycle 14.
REQ-025 SHALL pass this scenario: tready alternating 1/0 -> all 11 words exactly once, in order, tdata stable during stalls, occupancy never >2.
REQ-026 SHALL pass this scenario: tready=0 for 20 cycles after first tvalid -> tvalid stays 1, tdata=0x100, only addresses 0 and 1 read, then the full frame completes when tready=1.
REQ-027 SHALL pass this scenario: in_start re-pulsed at cycle 5 -> ignored, exactly 11 beats, one out_done.
REQ-028 SHALL pass this scenario: aresetn=0 at cycle 6 for one cycle -> next cycle tvalid=0, busy=0, EN=0; later in_start replays from 0x100.
REQ-029 SHALL pass this scenario: in_start in the out_done cycle -> second frame's first beat 3 cycles later, with no stray beats between frames.
